fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus between fetch unit and memory
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  imem_resp_err
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output imem_resp_err
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM with flush and fault reporting
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_1000,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [31:0]         pc_i,
  input  logic                fetch_start_i,
  input  logic                flush_i,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr_o,
  output logic [31:0]         old_pc_o,
  output logic [31:0]         pc_plus4_o,
  output logic                pc_write_o,
  output logic                fetch_done_o,
  output logic                fetch_fault_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        pc_write_q, pc_write_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        kill_q, kill_d;
  logic        req_valid_q, req_valid_d;
  logic        busy_q, busy_d;
  logic        discard;

  // Next-state and registered-output computation; pulses default low every cycle
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    old_pc_d   = old_pc_q;
    pc_plus4_d = pc_plus4_q;
    kill_d     = kill_q;
    pc_write_d = 1'b0;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    // A flush arriving together with the response still kills it
    discard    = kill_q | flush_i;

    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (fetch_start_i) begin
          if (pc_i[1:0] == 2'b00) begin
            addr_d  = pc_i;
            state_d = S_REQ;
          end else begin
            fault_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        // Responses are not legal before the handshake, so none are looked at here
        if (flush_i) kill_d = 1'b1;
        if (imem.imem_req_ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          state_d = S_IDLE;
          kill_d  = 1'b0;
          if (!discard) begin
            if (imem.imem_resp_err) begin
              fault_d = 1'b1;
            end else begin
              instr_d    = imem.imem_resp_data;
              old_pc_d   = addr_q;
              pc_plus4_d = addr_q + 32'd4;
              pc_write_d = 1'b1;
              done_d     = 1'b1;
            end
          end
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
    endcase

    req_valid_d = (state_d == S_REQ);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      addr_q      <= RESET_PC;
      instr_q     <= RESET_INSTR;
      old_pc_q    <= RESET_PC;
      pc_plus4_q  <= RESET_PC + 32'd4;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      old_pc_q    <= old_pc_d;
      pc_plus4_q  <= pc_plus4_d;
      pc_write_q  <= pc_write_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_req_addr  = addr_q;
  assign instr_o             = instr_q;
  assign old_pc_o            = old_pc_q;
  assign pc_plus4_o          = pc_plus4_q;
  assign pc_write_o          = pc_write_q;
  assign fetch_done_o        = done_q;
  assign fetch_fault_o       = fault_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_start;
  logic        flush;
  logic [31:0] instr, old_pc, pc_plus4;
  logic        pc_write, fetch_done, fetch_fault, busy;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .pc_i          (pc),
    .fetch_start_i (fetch_start),
    .flush_i       (flush),
    .imem          (bus),
    .instr_o       (instr),
    .old_pc_o      (old_pc),
    .pc_plus4_o    (pc_plus4),
    .pc_write_o    (pc_write),
    .fetch_done_o  (fetch_done),
    .fetch_fault_o (fetch_fault),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [31:0] pc4;
    int          cyc;
  } evt_t;

  evt_t        exp_evt_q[$];
  logic [31:0] exp_req_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          prev_pulse = 0;

  // Architectural view kept by the bench
  logic [31:0] m_instr, m_old, m_pc4;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_instr = 32'h0000_0013;
    m_old   = 32'h0000_1000;
    m_pc4   = 32'h0000_1004;
  endtask

  // Monitor: request addresses and completion pulses against the queues
  always @(negedge clk) begin
    evt_t e;
    bit   pulse;
    pulse = pc_write | fetch_done | fetch_fault;
    if (!rst) begin
      if (bus.imem_req_valid) begin
        if (exp_req_q.size() == 0) begin
          chk("unexpected_req", bus.imem_req_addr, 32'hxxxx_xxxx);
        end else begin
          chk("req_addr", bus.imem_req_addr, exp_req_q[0]);
          if (bus.imem_req_ready) void'(exp_req_q.pop_front());
        end
      end
      if (pulse) begin
        chk("pcw_eq_done", {31'd0, pc_write}, {31'd0, fetch_done});
        chk("fault_excl", {31'd0, pc_write & fetch_fault}, 32'd0);
        chk("pulse_repeat", {31'd0, prev_pulse}, 32'd0);
        if (exp_evt_q.size() == 0) begin
          chk("unexpected_pulse", {31'd0, fetch_fault}, 32'hxxxx_xxxx);
        end else begin
          e = exp_evt_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
          chk("instr", instr, e.instr);
          chk("old_pc", old_pc, e.old_pc);
          chk("pc_plus4", pc_plus4, e.pc4);
        end
      end else if (exp_evt_q.size() != 0 && exp_evt_q[0].cyc < cyc) begin
        e = exp_evt_q.pop_front();
        chk("pulse_timeout", cyc, e.cyc);
      end
    end
    prev_pulse = pulse & !rst;
  end

  // One fetch transaction: memory behaviour and flush timing chosen up front
  task automatic do_fetch(input logic [31:0] a, input int rdly, input int sdly,
                          input bit err, input logic [31:0] data, input int fl);
    int   j;
    bit   killed;
    evt_t e;
    j = 0;
    killed = 0;
    fetch_start = 1'b1;
    pc = a;
    flush = 1'($urandom_range(0, 1));
    if (a[1:0] != 2'b00) begin
      e.fault = 1'b1; e.instr = m_instr; e.old_pc = m_old; e.pc4 = m_pc4; e.cyc = cyc + 1;
      exp_evt_q.push_back(e);
      tick();
      fetch_start = 1'b0; flush = 1'b0; pc = $urandom;
      chk("busy_after_misalign", {31'd0, busy}, 32'd0);
      tick();
      return;
    end
    exp_req_q.push_back(a);
    tick();
    for (int i = 0; i <= rdly; i++) begin
      chk("busy_req", {31'd0, busy}, 32'd1);
      bus.imem_req_ready  = (i == rdly);
      bus.imem_resp_valid = 1'($urandom_range(0, 1));
      bus.imem_resp_data  = $urandom;
      bus.imem_resp_err   = 1'($urandom_range(0, 1));
      fetch_start = 1'($urandom_range(0, 1));
      pc = $urandom & 32'hFFFF_FFFC;
      flush = (j == fl);
      if (j == fl) killed = 1;
      j++;
      tick();
    end
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    for (int i = 0; i <= sdly; i++) begin
      chk("busy_wait", {31'd0, busy}, 32'd1);
      fetch_start = 1'($urandom_range(0, 1));
      pc = $urandom & 32'hFFFF_FFFC;
      flush = (j == fl);
      if (j == fl) killed = 1;
      j++;
      if (i == sdly) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        bus.imem_resp_err   = err;
        if (!killed) begin
          if (!err) begin
            m_instr = data;
            m_old   = a;
            m_pc4   = a + 32'd4;
          end
          e.fault = err; e.instr = m_instr; e.old_pc = m_old; e.pc4 = m_pc4; e.cyc = cyc + 1;
          exp_evt_q.push_back(e);
        end
      end
      tick();
    end
    bus.imem_resp_valid = 1'b0;
    fetch_start = 1'b0;
    flush = 1'b0;
    chk("busy_idle", {31'd0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; pc = 32'd0; fetch_start = 1'b0; flush = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = 32'd0; bus.imem_resp_err = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_old_pc", old_pc, 32'h0000_1000);
    chk("rst_pc_plus4", pc_plus4, 32'h0000_1004);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_pulses", {29'd0, pc_write, fetch_done, fetch_fault}, 32'd0);
    tick();

    do_fetch(32'h0000_1000, 0, 0, 0, 32'h0050_0093, -1);
    do_fetch(32'h0000_1002, 0, 0, 0, 32'd0, -1);
    chk("misalign_instr", instr, 32'h0050_0093);
    do_fetch(32'h0000_2000, 4, 1, 0, $urandom, -1);
    do_fetch(32'h0000_2400, 0, 2, 1, $urandom, -1);
    do_fetch(32'h0000_2404, 0, 2, 0, 32'hDEAD_BEEF, 1);
    chk("flush_instr", instr, m_instr);
    do_fetch(32'h0000_2800, 1, 0, 0, $urandom, -1);
    do_fetch(32'hFFFF_FFFC, 0, 1, 0, $urandom, -1);
    chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      do_fetch(a, $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 5) == 0), $urandom,
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1);
    end

    // Reset while waiting for the response
    fetch_start = 1'b1; pc = 32'h0000_3000;
    exp_req_q.push_back(32'h0000_3000);
    tick();
    fetch_start = 1'b0; bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("wait_rst_busy", {31'd0, busy}, 32'd0);
    chk("wait_rst_old_pc", old_pc, 32'h0000_1000);
    chk("wait_rst_instr", instr, 32'h0000_0013);
    chk("wait_rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h1234_5678; bus.imem_resp_err = 1'b0;
    tick();
    bus.imem_resp_valid = 1'b0;
    tick(); tick();
    chk("post_rst_instr", instr, 32'h0000_0013);
    do_fetch(32'h0000_4000, 0, 0, 0, 32'h0000_0073, -1);

    tick(); tick(); tick();
    chk("evt_q_empty", exp_evt_q.size(), 32'd0);
    chk("req_q_empty", exp_req_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
